// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_issue_ctrl : issues one op to a combinational ALU, waits its settle time,
//                  returns the captured {ZHI,ZLO} on a valid/ready channel.
// Revision: 1.0
// ----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int BITS       = 32,
  parameter int SIG_COUNT  = 13,
  parameter int BASIC_LAT  = 1,
  parameter int MULDIV_LAT = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [3:0]             req_op,
  input  logic [BITS-1:0]        req_x,
  input  logic [BITS-1:0]        req_y,
  output logic [SIG_COUNT-1:0]   alu_ctrl,
  output logic [BITS-1:0]        alu_x,
  output logic [BITS-1:0]        alu_y,
  input  logic [2*BITS-1:0]      alu_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [BITS-1:0]        z_hi,
  output logic [BITS-1:0]        z_lo,
  output logic [3:0]             rsp_op,
  output logic                   err_illegal,
  output logic                   err_div0
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MAX = 4'(SIG_COUNT - 1);

  localparam int LAT_MAX = (MULDIV_LAT > BASIC_LAT) ? MULDIV_LAT : BASIC_LAT;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  localparam logic [CNT_W-1:0] BASIC_CNT  = CNT_W'(BASIC_LAT - 1);
  localparam logic [CNT_W-1:0] MULDIV_CNT = CNT_W'(MULDIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [SIG_COUNT-1:0] CTRL_ONE = SIG_COUNT'(1);

  logic [1:0]           state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SIG_COUNT-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [BITS-1:0]      alu_x_q, alu_x_d;
  logic [BITS-1:0]      alu_y_q, alu_y_d;
  logic [BITS-1:0]      z_hi_q, z_hi_d;
  logic [BITS-1:0]      z_lo_q, z_lo_d;
  logic [3:0]           rsp_op_q, rsp_op_d;
  logic                 err_ill_q, err_ill_d;
  logic                 err_div0_q, err_div0_d;

  logic                 w_accept;
  logic                 w_illegal;
  logic                 w_div0;
  logic [CNT_W-1:0]     w_lat_cnt;

  assign req_ready = (state_q == ST_IDLE) | ((state_q == ST_RESP) & rsp_ready);
  assign w_accept  = req_valid & req_ready;
  assign w_illegal = (req_op > OP_MAX);
  assign w_div0    = (req_op == OP_DIV) && (req_y == '0);
  assign w_lat_cnt = ((req_op == OP_MUL) || (req_op == OP_DIV)) ? MULDIV_CNT : BASIC_CNT;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    alu_ctrl_d = alu_ctrl_q;
    alu_x_d    = alu_x_q;
    alu_y_d    = alu_y_q;
    z_hi_d     = z_hi_q;
    z_lo_d     = z_lo_q;
    rsp_op_d   = rsp_op_q;
    err_ill_d  = err_ill_q;
    err_div0_d = err_div0_q;

    case (state_q)
      ST_EXEC: begin
        if (cnt_q == '0) begin
          {z_hi_d, z_lo_d} = alu_result;
          rsp_op_d   = op_q;
          alu_ctrl_d = '0;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: ;
      default: state_d = ST_IDLE;
    endcase

    // Accept only happens in IDLE/RESP, so it overrides the consume-to-IDLE move above.
    if (w_accept) begin
      if (w_illegal || w_div0) begin
        z_hi_d     = '0;
        z_lo_d     = '0;
        err_ill_d  = w_illegal;
        err_div0_d = w_div0;
        rsp_op_d   = req_op;
        alu_ctrl_d = '0;
        state_d    = ST_RESP;
      end else begin
        op_d       = req_op;
        alu_ctrl_d = CTRL_ONE << req_op;
        alu_x_d    = req_x;
        alu_y_d    = req_y;
        cnt_d      = w_lat_cnt;
        err_ill_d  = 1'b0;
        err_div0_d = 1'b0;
        state_d    = ST_EXEC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      alu_ctrl_q <= '0;
      alu_x_q    <= '0;
      alu_y_q    <= '0;
      z_hi_q     <= '0;
      z_lo_q     <= '0;
      rsp_op_q   <= '0;
      err_ill_q  <= 1'b0;
      err_div0_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      alu_ctrl_q <= alu_ctrl_d;
      alu_x_q    <= alu_x_d;
      alu_y_q    <= alu_y_d;
      z_hi_q     <= z_hi_d;
      z_lo_q     <= z_lo_d;
      rsp_op_q   <= rsp_op_d;
      err_ill_q  <= err_ill_d;
      err_div0_q <= err_div0_d;
    end
  end

  assign alu_ctrl    = alu_ctrl_q;
  assign alu_x       = alu_x_q;
  assign alu_y       = alu_y_q;
  assign rsp_valid   = (state_q == ST_RESP);
  assign z_hi        = z_hi_q;
  assign z_lo        = z_lo_q;
  assign rsp_op      = rsp_op_q;
  assign err_illegal = err_ill_q;
  assign err_div0    = err_div0_q;

endmodule
`default_nettype wire
